// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - symbol encoding, FSM states and phase lengths for the Morse sequencer
package morse_pkg;

  localparam logic [1:0] SYM_END   = 2'b00;
  localparam logic [1:0] SYM_DOT   = 2'b01;
  localparam logic [1:0] SYM_DASH  = 2'b10;
  localparam logic [1:0] SYM_PAUSE = 2'b11;

  localparam logic [1:0] UNITS_DOT   = 2'd1;
  localparam logic [1:0] UNITS_GAP   = 2'd1;
  localparam logic [1:0] UNITS_DASH  = 2'd3;
  localparam logic [1:0] UNITS_PAUSE = 2'd3;
  localparam logic [1:0] UNITS_TAIL  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TONE,
    ST_GAP,
    ST_SILENT,
    ST_TAIL,
    ST_DONE
  } state_t;

  // END maps to the tail length: an END symbol leads straight into TAIL.
  function automatic logic [1:0] sym_units(input logic [1:0] sym);
    case (sym)
      SYM_DOT:   return UNITS_DOT;
      SYM_DASH:  return UNITS_DASH;
      SYM_PAUSE: return UNITS_PAUSE;
      default:   return UNITS_TAIL;
    endcase
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - phase down-counter; expire pulses in the last cycle of a 1- or 3-unit phase
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 12_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] units,
  output logic       expire
);

  localparam int W = $clog2(3 * UNIT_CYCLES);

  logic [W-1:0] cnt;
  logic [W-1:0] reload;
  logic         armed;

  assign reload = W'(int'(units) * UNIT_CYCLES - 1);
  assign expire = armed && (cnt == '0);

  // armed keeps a finished phase from pulsing expire again while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= reload;
      armed <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end else begin
      armed <= 1'b0;
    end
  end

endmodule

// File: rtl/morse_sequencer.sv
// rtl/morse_sequencer.sv - plays a 10-bit Morse word as timed short/long tone requests; MORSE_QUEUE_EN adds a one-entry pending word
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [9:0] code,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic       long,
  output logic       audio_en,
  output logic [2:0] sym_idx
);

  state_t     state;
  logic [9:0] word_q;
  logic       expire;
  logic       load;
  logic       accept;
  logic       start_req;
  logic [9:0] accept_code;
  logic [1:0] dec_sym;
  logic [1:0] tim_units;
  logic [2:0] nxt_idx;
  state_t     ph_state;
  logic       ph_short;
  logic       ph_long;

`ifdef MORSE_QUEUE_EN
  logic       pend_valid;
  logic [9:0] pend_code;
  assign start_req   = start || pend_valid;
  assign accept_code = pend_valid ? pend_code : code;
`else
  assign start_req   = start;
  assign accept_code = code;
`endif

  assign audio_en = busy;

  always_comb begin
    accept  = (state == ST_IDLE) && start_req && !abort;
    nxt_idx = sym_idx + 3'd1;
    // Past symbol 4 the shift brings in zeros, which decode as END.
    dec_sym = (state == ST_IDLE) ? accept_code[1:0] : 2'(word_q >> {nxt_idx, 1'b0});
    ph_state = ST_TAIL;
    ph_short = 1'b0;
    ph_long  = 1'b0;
    case (dec_sym)
      SYM_DOT:   begin ph_state = ST_TONE; ph_short = 1'b1; end
      SYM_DASH:  begin ph_state = ST_TONE; ph_long  = 1'b1; end
      SYM_PAUSE: ph_state = ST_SILENT;
      default:   ph_state = ST_TAIL;
    endcase
    load      = accept || (expire && (state inside {ST_TONE, ST_GAP, ST_SILENT}));
    tim_units = (state == ST_TONE) ? UNITS_GAP : sym_units(dec_sym);
  end

  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .units  (tim_units),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      word_q  <= '0;
      sym_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      short   <= 1'b0;
      long    <= 1'b0;
`ifdef MORSE_QUEUE_EN
      pend_valid <= 1'b0;
      pend_code  <= '0;
`endif
    end else if (abort) begin
      state   <= ST_IDLE;
      sym_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      short   <= 1'b0;
      long    <= 1'b0;
`ifdef MORSE_QUEUE_EN
      pend_valid <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          word_q  <= accept_code;
          sym_idx <= '0;
          busy    <= 1'b1;
          state   <= ph_state;
          short   <= ph_short;
          long    <= ph_long;
        end
        ST_TONE: if (expire) begin
          state <= ST_GAP;
          short <= 1'b0;
          long  <= 1'b0;
        end
        ST_GAP, ST_SILENT: if (expire) begin
          sym_idx <= nxt_idx;
          state   <= ph_state;
          short   <= ph_short;
          long    <= ph_long;
        end
        ST_TAIL: if (expire) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          sym_idx <= '0;
        end
        default: state <= ST_IDLE;
      endcase
`ifdef MORSE_QUEUE_EN
      if (accept) pend_valid <= 1'b0;
      if (start && state != ST_IDLE) begin
        pend_valid <= 1'b1;
        pend_code  <= code;
      end
`endif
    end
  end

endmodule
